// File: rtl/video_sync_decoder_pkg.sv
// Shared video definitions: lock FSM states and the 640x480 timing constants
// that the timing generator and this decoder both use.
package video_sync_decoder_pkg;

    localparam int   VGA_HOR_TOTAL    = 800;
    localparam int   VGA_HOR_ACTIVE   = 640;
    localparam logic VGA_HOR_SYNC_POL = 1'b0;
    localparam int   VGA_VER_TOTAL    = 525;
    localparam int   VGA_VER_ACTIVE   = 480;
    localparam logic VGA_VER_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/video_sync_decoder_edge.sv
// Polarity normalisation and assertion/deassertion detection for one sync or
// data-enable input. The previous sample only advances on enabled cycles.
module sync_edge_detect #(
    parameter logic POLARITY = 1'b1
) (
    input  logic clk_rgb,
    input  logic rst_n,
    input  logic ce,
    input  logic sig,
    output logic active,
    output logic asserted,
    output logic deasserted
);

    logic prev_active;

    assign active     = (sig == POLARITY);
    assign asserted   = ce & active & ~prev_active;
    assign deasserted = ce & ~active & prev_active;

    // Reset to the inactive level so a level already asserted at release
    // still produces an edge on the first enabled sample.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            prev_active <= 1'b0;
        end else if (ce) begin
            prev_active <= active;
        end
    end

endmodule

// File: rtl/video_sync_decoder.sv
// Recovers pixel coordinates and line/frame strobes from a raw hs/vs/de
// stream, and only qualifies pixels after LOCK_FRAMES clean frames.
module video_sync_decoder
    import video_sync_decoder_pkg::*;
#(
    parameter int   HOR_TOTAL_PIXELS  = VGA_HOR_TOTAL,
    parameter int   HOR_ACTIVE_PIXELS = VGA_HOR_ACTIVE,
    parameter logic HOR_SYNC_POLARITY = VGA_HOR_SYNC_POL,
    parameter int   VER_TOTAL_PIXELS  = VGA_VER_TOTAL,
    parameter int   VER_ACTIVE_PIXELS = VGA_VER_ACTIVE,
    parameter logic VER_SYNC_POLARITY = VGA_VER_SYNC_POL,
    parameter int   LOCK_FRAMES       = 2,
    localparam int  X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    localparam int  Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk_rgb,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               hs,
    input  logic               vs,
    input  logic               de,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               valid,
    output logic               line_start,
    output logic               frame_start,
    output logic               locked,
    output logic               err
);

    localparam int HW = $clog2(HOR_TOTAL_PIXELS + 1);
    localparam int VW = $clog2(VER_TOTAL_PIXELS + 1);
    localparam int CW = $clog2(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] H_TOTAL    = HW'(HOR_TOTAL_PIXELS);
    localparam logic [HW-1:0] H_ACTIVE   = HW'(HOR_ACTIVE_PIXELS);
    localparam logic [VW:0]   V_TOTAL    = (VW+1)'(VER_TOTAL_PIXELS);
    localparam logic [VW:0]   V_ACTIVE   = (VW+1)'(VER_ACTIVE_PIXELS);
    localparam logic [CW-1:0] CLEAN_LAST = CW'(LOCK_FRAMES - 1);

    logic hs_active, hs_assert, hs_deassert;
    logic vs_active, vs_assert, vs_deassert;
    logic de_active, de_rise, de_fall;
    logic unused_edges;

    sync_edge_detect #(.POLARITY(HOR_SYNC_POLARITY)) u_hs_edge (
        .clk_rgb, .rst_n, .ce, .sig(hs),
        .active(hs_active), .asserted(hs_assert), .deasserted(hs_deassert)
    );
    sync_edge_detect #(.POLARITY(VER_SYNC_POLARITY)) u_vs_edge (
        .clk_rgb, .rst_n, .ce, .sig(vs),
        .active(vs_active), .asserted(vs_assert), .deasserted(vs_deassert)
    );
    sync_edge_detect #(.POLARITY(1'b1)) u_de_edge (
        .clk_rgb, .rst_n, .ce, .sig(de),
        .active(de_active), .asserted(de_rise), .deasserted(de_fall)
    );

    assign unused_edges = hs_active ^ hs_deassert ^ vs_deassert;

    lock_state_t   state, state_nxt;
    logic [CW-1:0] clean_cnt, clean_nxt;
    logic          h_armed, frame_err;
    logic [HW-1:0] h_cnt, de_cnt, de_base, de_cnt_nxt;
    logic [VW-1:0] line_cnt, act_cnt, line_cnt_nxt, act_cnt_nxt;
    logic [VW:0]   lines_closed, acts_closed;
    logic          err_now, lock_nxt;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a value unassigned and infers a latch.
    always_comb begin
        de_base = hs_assert ? '0 : de_cnt;
        // hs is counted before the frame closes when both assert together.
        lines_closed = {1'b0, line_cnt} + {{VW{1'b0}}, hs_assert};
        acts_closed  = {1'b0, act_cnt} + {{VW{1'b0}}, de_fall};

        err_now = (state != SEARCH) && (
                      (de_fall && de_cnt != H_ACTIVE) ||
                      (hs_assert && h_armed && h_cnt != H_TOTAL) ||
                      (vs_assert && (lines_closed != V_TOTAL || acts_closed != V_ACTIVE)) ||
                      (ce && de_active && vs_active));

        state_nxt = state;
        clean_nxt = clean_cnt;
        if (err_now) begin
            state_nxt = CHECK;
            clean_nxt = '0;
        end else if (vs_assert) begin
            if (state == SEARCH) begin
                // The frame closed on entry was only partly observed.
                state_nxt = CHECK;
                clean_nxt = '0;
            end else if (frame_err) begin
                clean_nxt = '0;
            end else if (state == CHECK) begin
                clean_nxt = clean_cnt + 1'b1;
                if (clean_cnt == CLEAN_LAST) state_nxt = LOCKED;
            end
        end
        lock_nxt = (state_nxt == LOCKED);

        if (de_active) begin
            de_cnt_nxt = (de_base == '1) ? de_base : de_base + 1'b1;
        end else if (de_fall) begin
            de_cnt_nxt = '0;
        end else begin
            de_cnt_nxt = de_base;
        end

        line_cnt_nxt = line_cnt;
        act_cnt_nxt  = act_cnt;
        if (vs_assert) begin
            line_cnt_nxt = '0;
            act_cnt_nxt  = '0;
        end else begin
            if (hs_assert && line_cnt != '1) line_cnt_nxt = line_cnt + 1'b1;
            if (de_fall && act_cnt != '1)    act_cnt_nxt  = act_cnt + 1'b1;
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            clean_cnt   <= '0;
            h_armed     <= 1'b0;
            frame_err   <= 1'b0;
            h_cnt       <= '0;
            de_cnt      <= '0;
            line_cnt    <= '0;
            act_cnt     <= '0;
            x           <= '0;
            y           <= '0;
            valid       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else if (ce) begin
            state     <= state_nxt;
            clean_cnt <= clean_nxt;
            h_armed   <= (state == SEARCH) ? 1'b0 : (h_armed | hs_assert);
            frame_err <= vs_assert ? 1'b0 : (frame_err | err_now);
            h_cnt     <= hs_assert ? HW'(1) : ((h_cnt == '1) ? h_cnt : h_cnt + 1'b1);
            de_cnt    <= de_cnt_nxt;
            line_cnt  <= line_cnt_nxt;
            act_cnt   <= act_cnt_nxt;
            if (de_active) begin
                x <= X_WIDTH'(de_base);
                y <= Y_WIDTH'(act_cnt);
            end
            valid       <= de_active && lock_nxt;
            line_start  <= de_rise && lock_nxt;
            frame_start <= de_rise && lock_nxt && (act_cnt == '0);
            err         <= err_now;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder on a reduced 20x12 (12x8 active) mode
// driven by a small in-bench timing generator.
module tb_video_sync_decoder;

    localparam int HT = 20, HA = 12, VT = 12, VA = 8;
    localparam int HS_START = 14, HS_WIDTH = 2, VS_LINE = 9;
    localparam int FRAME  = HT * VT;
    localparam int VS_POS = VS_LINE * HT + HS_START;

    logic clk_rgb = 1'b0, rst_n = 1'b0, ce = 1'b0;
    logic hs = 1'b1, vs = 1'b1, de = 1'b0;
    logic [3:0] x;
    logic [2:0] y;
    logic valid, line_start, frame_start, locked, err;

    int tests = 0, fails = 0;
    int gh = 0, gv = 0, gen_ht = HT, short_line = -1;
    int n_err, n_ls, n_fs, n_valid, n_lock_rise, last_x, last_y;
    logic prev_locked = 1'b0;

    video_sync_decoder #(
        .HOR_TOTAL_PIXELS(HT), .HOR_ACTIVE_PIXELS(HA), .HOR_SYNC_POLARITY(1'b0),
        .VER_TOTAL_PIXELS(VT), .VER_ACTIVE_PIXELS(VA), .VER_SYNC_POLARITY(1'b0),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_rgb(clk_rgb), .rst_n(rst_n), .ce(ce), .hs(hs), .vs(vs), .de(de),
        .x(x), .y(y), .valid(valid), .line_start(line_start),
        .frame_start(frame_start), .locked(locked), .err(err)
    );

    always #5 clk_rgb = ~clk_rgb;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic gen_de();
        return (gv < VA) && (gh < ((gv == short_line) ? HA - 1 : HA));
    endfunction

    function automatic logic gen_vs_act();
        return (gv == VS_LINE && gh >= HS_START) || (gv == VS_LINE + 1) ||
               (gv == VS_LINE + 2 && gh < HS_START);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_err = 0; n_ls = 0; n_fs = 0; n_valid = 0; n_lock_rise = 0;
        last_x = -1; last_y = -1;
        prev_locked = locked;
    endtask

    // Drive the current generator pixel, let the DUT sample it, then observe.
    task automatic tick(input logic en);
        ce = en;
        de = gen_de();
        hs = (gh >= HS_START && gh < HS_START + HS_WIDTH) ? 1'b0 : 1'b1;
        vs = gen_vs_act() ? 1'b0 : 1'b1;
        @(posedge clk_rgb);
        #1;
        if (en) begin
            gh++;
            if (gh == gen_ht) begin
                gh = 0;
                gv = (gv == VT - 1) ? 0 : gv + 1;
            end
        end
        if (err === 1'b1) n_err++;
        if (line_start === 1'b1) n_ls++;
        if (frame_start === 1'b1) n_fs++;
        if (valid === 1'b1) begin
            n_valid++;
            last_x = int'(x);
            last_y = int'(y);
        end
        if (locked === 1'b1 && prev_locked !== 1'b1) n_lock_rise++;
        prev_locked = locked;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    initial begin
        int bad;
        int cgh, cgv;
        logic cde, exp_lock, exp_ls;
        logic [3:0] sx;
        logic [2:0] sy;
        logic sv, sl;

        // Reset state
        repeat (3) tick(1'b0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_valid", valid, 0);
        check("rst_line_start", line_start, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Lock acquisition: SEARCH at vs #1, clean frames close at vs #2 and #3
        clear_mon();
        run(2 * FRAME + VS_POS);
        check("acq_locked_before_vs3", locked, 0);
        check("acq_err_count", n_err, 0);
        tick(1'b1);
        check("acq_locked_at_vs3", locked, 1);
        run(FRAME - VS_POS - 1);
        clear_mon();
        tick(1'b1);
        check("first_frame_start", frame_start, 1);
        check("first_line_start", line_start, 1);
        check("first_x", x, 0);
        check("first_y", y, 0);
        check("first_valid", valid, 1);
        run(FRAME - 1);
        check("frame_line_starts", n_ls, VA);
        check("frame_valid_cycles", n_valid, HA * VA);
        check("frame_starts", n_fs, 1);
        check("last_valid_x", last_x, HA - 1);
        check("last_valid_y", last_y, VA - 1);
        check("locked_frame_err", n_err, 0);
        check("locked_after_frame", locked, 1);

        // Short active line after lock
        short_line = 3;
        clear_mon();
        run(3 * HT + HA - 1);
        check("short_pre_err", n_err, 0);
        check("short_pre_locked", locked, 1);
        tick(1'b1);
        short_line = -1;
        check("short_err_pulse", err, 1);
        check("short_locked_drop", locked, 0);
        check("short_valid_drop", valid, 0);
        clear_mon();
        run(2 * FRAME - (3 * HT + HA) + VS_POS);
        check("relock_no_valid", n_valid, 0);
        check("relock_no_err", n_err, 0);
        check("relock_pending", locked, 0);
        tick(1'b1);
        check("relock_locked", locked, 1);
        run(FRAME - VS_POS - 1);

        // Every line one clock too long
        gen_ht = HT + 1;
        clear_mon();
        run(3 * VT * (HT + 1));
        check("long_line_err_count", n_err, 3 * VT - 1);
        check("long_line_lock_rises", n_lock_rise, 0);
        check("long_line_locked", locked, 0);
        gen_ht = HT;

        // Clock enable low on every other cycle, generator gated alike
        rst_n = 1'b0;
        tick(1'b0);
        tick(1'b0);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 4 * FRAME; k++) begin
            cgh = gh;
            cgv = gv;
            cde = gen_de();
            tick(1'b1);
            exp_lock = (k >= 2 * FRAME + VS_POS);
            exp_ls   = (cgh == 0) && (cgv < VA) && exp_lock;
            if (locked !== exp_lock || valid !== (cde && exp_lock) ||
                line_start !== exp_ls || frame_start !== (exp_ls && cgv == 0) ||
                err !== 1'b0) bad++;
            if (cde && (x !== 4'(cgh) || y !== 3'(cgv))) bad++;
            sx = x; sy = y; sv = valid; sl = locked;
            tick(1'b0);
            if (x !== sx || y !== sy || valid !== sv || locked !== sl ||
                line_start !== 1'b0 || frame_start !== 1'b0 || err !== 1'b0) bad++;
        end
        check("ce_sequence_mismatches", bad, 0);
        check("ce_locked", locked, 1);

        // Asynchronous reset mid-frame
        run(3 * HT + 5);
        tick(1'b1);
        check("mid_valid", valid, 1);
        check("mid_x", x, 5);
        check("mid_y", y, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {x, y, valid, line_start, frame_start, locked, err}, 0);
        repeat (3) tick(1'b1);
        rst_n = 1'b1;
        clear_mon();
        run((FRAME - (3 * HT + 9)) + FRAME + VS_POS);
        check("post_rst_no_valid", n_valid, 0);
        check("post_rst_unlocked", locked, 0);
        tick(1'b1);
        check("post_rst_locked", locked, 1);
        run(FRAME - VS_POS - 1);
        tick(1'b1);
        check("post_rst_frame_start", frame_start, 1);
        check("post_rst_valid", valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
